// File: rtl/cia_pipe_adder.sv
// cia_pipe_adder: pipelined carry-increment adder/subtractor with a
// valid/ready handshake on both sides and full back-pressure.
// One register stage per BLK-bit carry-increment block, so the latency
// from accept to out_valid is NBLK = WIDTH/BLK cycles.
// Optional feature: define CIA_PIPE_OVF_EN to add a registered
// two's-complement overflow output (ovf) aligned with sum/cout.
module cia_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CIA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK = (BLK == 0) ? 0 : (WIDTH / BLK);

  // Reject shapes that cannot be split into at least two whole blocks.
  if (BLK == 0 || (WIDTH % BLK) != 0 || NBLK < 2) begin : g_bad_params
    $error("cia_pipe_adder: WIDTH must be a multiple of BLK and WIDTH/BLK >= 2");
  end

  // One carry-increment block: raw BLK-bit sum with carry-in 0, then a
  // half-adder chain that adds the incoming block carry to the raw sum.
  // Result is {carry_out, sum_slice}.
  function automatic logic [BLK:0] cia_block(
    input logic [BLK-1:0] x,
    input logic [BLK-1:0] y,
    input logic           c
  );
    logic [BLK:0]   raw;
    logic [BLK-1:0] inc;
    logic           hc;
    raw = {1'b0, x} + {1'b0, y};
    hc  = c;
    inc = '0;
    for (int unsigned i = 0; i < BLK; i++) begin
      inc[i] = raw[i] ^ hc;
      hc     = raw[i] & hc;
    end
    return {raw[BLK] | hc, inc};
  endfunction

  logic             en;
  logic             last_vld;
  logic [WIDTH-1:0] b_cond;
  logic             carry0;

  // Whole pipeline advances together; it only freezes when the output
  // holds a result that downstream is refusing.
  assign en        = ~(last_vld & ~out_ready);
  assign in_ready  = en;

  // Operand conditioning: subtraction is a + ~b + 1, cin ignored.
  always_comb begin
    b_cond = sub ? ~b : b;
    carry0 = sub ? 1'b1 : cin;
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    // IW: operand bits not yet consumed on entry to this stage.
    // SW: resolved sum bits held by this stage's register.
    localparam int unsigned IW = WIDTH - k * BLK;
    localparam int unsigned SW = (k + 1) * BLK;

    logic [IW-1:0] a_src;
    logic [IW-1:0] b_src;
    logic          c_src;
    logic          v_src;
    logic [BLK:0]  blk_res;
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;
    logic          carry_d;
    logic          carry_q;
    logic          vld_d;
    logic          vld_q;

    if (k == 0) begin : g_src
      assign a_src = a;
      assign b_src = b_cond;
      assign c_src = carry0;
      assign v_src = in_valid;
      assign sum_d = blk_res[BLK-1:0];
    end else begin : g_src
      assign a_src = g_stage[k-1].g_fwd.a_q;
      assign b_src = g_stage[k-1].g_fwd.b_q;
      assign c_src = g_stage[k-1].carry_q;
      assign v_src = g_stage[k-1].vld_q;
      assign sum_d = {blk_res[BLK-1:0], g_stage[k-1].sum_q};
    end

    assign blk_res = cia_block(a_src[BLK-1:0], b_src[BLK-1:0], c_src);
    assign carry_d = blk_res[BLK];
    assign vld_d   = v_src;

    // Stage register: resolved low slices, block carry and valid bit.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        vld_q   <= 1'b0;
      end else if (en) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        vld_q   <= vld_d;
      end
    end

    if (k < NBLK - 1) begin : g_fwd
      // Skewed operands: only the slices later stages still need.
      logic [IW-BLK-1:0] a_d;
      logic [IW-BLK-1:0] b_d;
      logic [IW-BLK-1:0] a_q;
      logic [IW-BLK-1:0] b_q;

      assign a_d = a_src[IW-1:BLK];
      assign b_d = b_src[IW-1:BLK];

      // Operand skew register for the remaining upper blocks.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef CIA_PIPE_OVF_EN
    if (k == NBLK - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is a^b^sum at that bit; overflow is that
      // carry XOR the carry out of the MSB.
      assign ovf_d = a_src[BLK-1] ^ b_src[BLK-1] ^ blk_res[BLK-1] ^ blk_res[BLK];

      // Overflow flag registered alongside the final sum slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign last_vld  = g_stage[NBLK-1].vld_q;
  assign out_valid = last_vld;
  assign sum       = g_stage[NBLK-1].sum_q;
  assign cout      = g_stage[NBLK-1].carry_q;
`ifdef CIA_PIPE_OVF_EN
  assign ovf       = g_stage[NBLK-1].g_ovf.ovf_q;
`endif

endmodule
